// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Memory-side responder for the core's data-memory port. Accepts one word request
//   at a time, latches it, waits a fixed LATENCY, then performs the access on the
//   internal storage array and returns a one-cycle mem_ready pulse with the data.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst_b         synchronous reset, active-high (legacy name)
//   mem_req       request strobe, only sampled while idle
//   mem_addr      byte address; bits [1:0] ignored
//   mem_write_en  1 = write, 0 = read
//   mem_data_in   write byte lanes, lane i -> byte offset i
//   mem_data_out  response byte lanes, held until the next response
//   mem_ready     one-cycle completion pulse
//   mem_error     out-of-range flag, valid only with mem_ready
//   busy          high from acceptance through the mem_ready cycle
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            mem_req,
  input  logic [31:0]     mem_addr,
  input  logic            mem_write_en,
  input  logic [0:3][7:0] mem_data_in,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_ready,
  output logic            mem_error,
  output logic            busy
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One extra bit so the byte span cannot overflow for very large depths.
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          r_state, w_state_next;
  logic [3:0]      r_count, w_count_next;
  logic [31:0]     r_addr, w_addr_next;
  logic            r_we, w_we_next;
  logic [0:3][7:0] r_wdata, w_wdata_next;
  logic [0:3][7:0] r_rdata, w_rdata_next;
  logic            r_ready, w_ready_next;
  logic            r_error, w_error_next;

  logic [0:3][7:0] r_mem [DEPTH_WORDS];

  logic [31:0]     w_off;
  logic            w_in_range;
  logic [IdxW-1:0] w_idx;

  // Translation works on the latched address so late input changes cannot leak in.
  always_comb begin
    w_off      = r_addr - BASE_ADDR;
    w_in_range = ({1'b0, w_off} < SpanBytes);
    w_idx      = w_off[IdxW+1:2];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state <= StIdle;
      r_count <= 4'd0;
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_addr  <= w_addr_next;
      r_we    <= w_we_next;
      r_wdata <= w_wdata_next;
      r_rdata <= w_rdata_next;
      r_ready <= w_ready_next;
      r_error <= w_error_next;
    end
  end

  // Storage is never cleared; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst_b && (r_state == StResp) && r_we && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_addr_next  = r_addr;
    w_we_next    = r_we;
    w_wdata_next = r_wdata;
    w_rdata_next = r_rdata;
    w_ready_next = 1'b0;
    w_error_next = 1'b0;
    case (r_state)
      StIdle: begin
        if (mem_req) begin
          w_addr_next  = mem_addr;
          w_we_next    = mem_write_en;
          w_wdata_next = mem_data_in;
          w_count_next = 4'(LATENCY - 1);
          w_state_next = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        w_count_next = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        w_ready_next = 1'b1;
        w_error_next = !w_in_range;
        if (!w_in_range) begin
          w_rdata_next = '0;
        end else if (r_we) begin
          w_rdata_next = r_wdata;
        end else begin
          w_rdata_next = r_mem[w_idx];
        end
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs. The FSM is already idle during the mem_ready cycle, so busy
  // also covers that cycle via the ready flag.
  always_comb begin
    mem_data_out = r_rdata;
    mem_ready    = r_ready;
    mem_error    = r_error;
    busy         = (r_state != StIdle) || r_ready;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;

  // LATENCY = 3 instance
  logic            req, we, rdy, err, bsy;
  logic [31:0]     addr;
  logic [0:3][7:0] din, dout;

  // LATENCY = 1 instance
  logic            l1_req, l1_we, l1_rdy, l1_err, l1_bsy;
  logic [31:0]     l1_addr;
  logic [0:3][7:0] l1_din, l1_dout;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst_b(rst_b), .mem_req(req), .mem_addr(addr), .mem_write_en(we),
    .mem_data_in(din), .mem_data_out(dout), .mem_ready(rdy), .mem_error(err), .busy(bsy)
  );

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut_l1 (
    .clk(clk), .rst_b(rst_b), .mem_req(l1_req), .mem_addr(l1_addr), .mem_write_en(l1_we),
    .mem_data_in(l1_din), .mem_data_out(l1_dout), .mem_ready(l1_rdy), .mem_error(l1_err),
    .busy(l1_bsy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request on the LATENCY=3 instance; inputs are scrambled after
  // acceptance to show the latched copy is used.
  task automatic txn(input string tag, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic chk_data,
                     input logic [31:0] exp_data, input logic exp_err);
    addr = a; we = w; din = d; req = 1'b1;
    tick();                                   // edge N: accepted
    req = 1'b0; addr = 32'hFFFF_FFFC; we = ~w; din = 32'h5A5A_5A5A;
    chk({tag, "_busy_acc"}, 32'(bsy), 32'd1);
    chk({tag, "_rdy_acc"}, 32'(rdy), 32'd0);
    tick(); tick();                           // N+2
    chk({tag, "_rdy_early"}, 32'(rdy), 32'd0);
    tick();                                   // N+3
    chk({tag, "_rdy"}, 32'(rdy), 32'd1);
    chk({tag, "_busy_rdy"}, 32'(bsy), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (chk_data) chk({tag, "_data"}, dout, exp_data);
    tick();                                   // N+4
    chk({tag, "_rdy_drop"}, 32'(rdy), 32'd0);
    chk({tag, "_busy_drop"}, 32'(bsy), 32'd0);
    chk({tag, "_err_drop"}, 32'(err), 32'd0);
    if (chk_data) chk({tag, "_data_hold"}, dout, exp_data);
  endtask

  initial begin
    int rc;
    rst_b = 1'b1; req = 1'b0; addr = '0; we = 1'b0; din = '0;
    l1_req = 1'b0; l1_addr = '0; l1_we = 1'b0; l1_din = '0;
    tick(); tick();
    rst_b = 1'b0;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_l1_busy", 32'(l1_bsy), 32'd0);

    // Timing of a plain read; contents unknown so only handshake is checked.
    txn("rd10", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Write then read back, including an unaligned byte address.
    txn("wr20", 32'h20, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
    txn("rd20", 32'h20, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    txn("rd23", 32'h23, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Out of range: 0x1000 would alias word 0 if the range check were missing.
    txn("wr0", 32'h0, 1'b1, 32'h0102_0304, 1'b1, 32'h0102_0304, 1'b0);
    txn("wr1000", 32'h1000, 1'b1, 32'hFFFF_0000, 1'b1, 32'h0, 1'b1);
    txn("rd1000", 32'h1000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    txn("rd0", 32'h0, 1'b0, 32'h0, 1'b1, 32'h0102_0304, 1'b0);
    txn("rdffc", 32'hFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Held request: accepts at N, N+4, N+8; address changed while busy.
    addr = 32'h20; we = 1'b0; req = 1'b1;
    rc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) addr = 32'h0;
      if (k < 8 && rdy) rc++;
      if (k == 3) chk("held_data1", dout, 32'hDEAD_BEEF);
      if (k == 7) chk("held_data2", dout, 32'h0102_0304);
    end
    chk("held_count", 32'(rc), 32'd2);
    req = 1'b0;
    tick(); tick();
    chk("held_rdy3", 32'(rdy), 32'd1);
    tick();
    chk("held_idle", 32'(bsy), 32'd0);

    // Reset one cycle after a write is accepted abandons it.
    txn("wr40", 32'h40, 1'b1, 32'hAABB_CCDD, 1'b1, 32'hAABB_CCDD, 1'b0);
    addr = 32'h40; we = 1'b1; din = 32'h1122_3344; req = 1'b1;
    tick();
    req = 1'b0; rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("abort_busy", 32'(bsy), 32'd0);
    chk("abort_ready", 32'(rdy), 32'd0);
    chk("abort_data", dout, 32'd0);
    rc = 0;
    repeat (4) begin
      tick();
      if (rdy) rc++;
    end
    chk("abort_no_ready", 32'(rc), 32'd0);

    // Reset and request on the same edge: reset wins.
    addr = 32'h40; we = 1'b1; din = 32'h1122_3344; req = 1'b1; rst_b = 1'b1;
    tick();
    req = 1'b0; rst_b = 1'b0;
    tick();
    chk("rst_req_busy", 32'(bsy), 32'd0);
    txn("rd40", 32'h40, 1'b0, 32'h0, 1'b1, 32'hAABB_CCDD, 1'b0);

    // LATENCY=1: write then back-to-back read-after-write.
    l1_addr = 32'h8; l1_we = 1'b1; l1_din = 32'hCAFE_F00D; l1_req = 1'b1;
    tick();                                   // edge N
    l1_we = 1'b0; l1_din = '0;
    chk("l1_busy_acc", 32'(l1_bsy), 32'd1);
    chk("l1_rdy_acc", 32'(l1_rdy), 32'd0);
    tick();                                   // N+1
    chk("l1_rdy1", 32'(l1_rdy), 32'd1);
    chk("l1_data1", l1_dout, 32'hCAFE_F00D);
    tick();                                   // N+2: second accept
    l1_req = 1'b0;
    chk("l1_rdy_gap", 32'(l1_rdy), 32'd0);
    chk("l1_busy_acc2", 32'(l1_bsy), 32'd1);
    tick();                                   // N+3
    chk("l1_rdy2", 32'(l1_rdy), 32'd1);
    chk("l1_data2", l1_dout, 32'hCAFE_F00D);
    chk("l1_err2", 32'(l1_err), 32'd0);
    tick();                                   // N+4
    chk("l1_idle", 32'(l1_bsy), 32'd0);
    chk("l1_rdy_drop", 32'(l1_rdy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
